// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT stream definitions: default field widths, read-side state encoding and
// the index bit-reverse helper used by the SDF stages and the reorder buffer.
package fft_bitrev_reorder_pkg;

    localparam int FFT_WIDTH    = 16;
    localparam int FFT_LOG_N    = 6;
    localparam int BITREV_MAX_W = 16;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Reverse the low n bits of idx; bits above n come back as zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] idx,
                                                       input int n);
        logic [BITREV_MAX_W-1:0] r;
        r = {<<{idx}};
        return r >> (BITREV_MAX_W - n);
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_bitrev_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port.
// Address is {bank, index}; the two ports never touch the same bank at once.
module bitrev_ram #(
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Output reorder stage of the SDF FFT: frames arrive in bit-reversed order, are
// double-buffered, and are replayed in natural order with a fixed 2-cycle read latency.
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int LOG_N = FFT_LOG_N
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i
);

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } sample_t;

    logic [LOG_N-1:0] wcnt;
    logic             wbank;
    logic [1:0]       bank_full;
    logic [LOG_N-1:0] rcnt;
    logic [LOG_N-1:0] rd_idx;
    logic             rbank;
    rd_state_t        rd_state;
    logic             rd_en_d;
    logic             wr_wrap;
    logic             rd_issue;
    logic             rd_last;
    sample_t          wr_data;
    sample_t          rd_data;

    assign wr_wrap  = idata_en && (&wcnt);
    // Issue straight out of IDLE so a completed bank is read on the very next edge;
    // this is what keeps back-to-back frames gapless on the output.
    assign rd_issue = (rd_state == RD_READ) || bank_full[rbank];
    assign rd_last  = (rd_state == RD_READ) && (&rcnt);
    assign rd_idx   = LOG_N'(bitrev(BITREV_MAX_W'(rcnt), LOG_N));
    assign wr_data  = '{re: idata_r, im: idata_i};

    bitrev_ram #(
        .DW (2*WIDTH),
        .AW (LOG_N+1)
    ) u_ram (
        .clock   (clock),
        .wr_en   (idata_en),
        .wr_addr ({wbank, wcnt}),
        .wr_data (wr_data),
        .rd_en   (rd_issue),
        .rd_addr ({rbank, rd_idx}),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (idata_en) begin
            wcnt <= wcnt + 1'b1;
            if (&wcnt) wbank <= ~wbank;
        end
    end

    // Writer sets and reader clears always land on different banks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_full <= '0;
        end else begin
            if (wr_wrap) bank_full[wbank] <= 1'b1;
            if (rd_last) bank_full[rbank] <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            rcnt     <= '0;
            rbank    <= 1'b0;
            rd_en_d  <= 1'b0;
            odata_en <= 1'b0;
        end else begin
            rd_en_d  <= rd_issue;
            odata_en <= rd_en_d;
            case (rd_state)
                RD_IDLE: begin
                    if (bank_full[rbank]) begin
                        rd_state <= RD_READ;
                        rcnt     <= rcnt + 1'b1;
                    end
                end
                RD_READ: begin
                    rcnt <= rcnt + 1'b1;
                    if (&rcnt) begin
                        rbank <= ~rbank;
                        if (!bank_full[~rbank]) rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        odata_r <= rd_data.re;
        odata_i <= rd_data.im;
    end

    always @(posedge clock) begin
        if (!reset) assert (!(wr_wrap && rd_last && (wbank == rbank)));
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: N=8 and N=64 instances, frame-level
// reference model, and a negedge monitor checking data, latency and contiguity.
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;
    localparam int W = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic         en3 = 1'b0, en6 = 1'b0;
    logic [W-1:0] r3 = '0, i3 = '0, r6 = '0, i6 = '0;
    logic         oen3, oen6;
    logic [W-1:0] or3, oi3, or6, oi6;

    fft_bitrev_reorder #(.WIDTH(W), .LOG_N(3)) dut3 (
        .clock(clock), .reset(reset), .idata_en(en3), .idata_r(r3), .idata_i(i3),
        .odata_en(oen3), .odata_r(or3), .odata_i(oi3));

    fft_bitrev_reorder #(.WIDTH(W), .LOG_N(6)) dut6 (
        .clock(clock), .reset(reset), .idata_en(en6), .idata_r(r6), .idata_i(i6),
        .odata_en(oen6), .odata_r(or6), .odata_i(oi6));

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] i;
        int           due;
    } exp_t;

    exp_t           q3[$], q6[$];
    logic [2*W-1:0] fb3[$], fb6[$];
    int cyc = 0, checks = 0, errors = 0;
    int last3 = 0, last6 = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int rev(input int n, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) r = r * 2 + ((n >> b) & 1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input logic en, input logic [W-1:0] r, input logic [W-1:0] i);
        exp_t e;
        int   last;
        if (en !== 1'b1) return;
        if ((k == 3 && q3.size() == 0) || (k == 6 && q6.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_n%0d: odata_en=1 r=%0d with nothing pending (cycle %0d)",
                     k, r, cyc);
            return;
        end
        if (k == 3) begin e = q3.pop_front(); last = last3; end
        else        begin e = q6.pop_front(); last = last6; end
        chk($sformatf("odata_r_n%0d", k), r, e.r);
        chk($sformatf("odata_i_n%0d", k), i, e.i);
        if (e.due >= 0) chk($sformatf("first_latency_n%0d", k), cyc, e.due);
        else            chk($sformatf("contiguous_n%0d", k), cyc, last + 1);
        if (k == 3) last3 = cyc; else last6 = cyc;
    endtask

    always @(negedge clock) begin
        mon(3, oen3, or3, oi3);
        mon(6, oen6, or6, oi6);
    end

    // A completed input frame produces N expectations in natural order; the first is
    // due 2 edges after the edge that samples the last input.
    task automatic push_frame(input int k);
        exp_t e;
        int   bits = (k == 3) ? 3 : 6;
        int   n_pts = 1 << bits;
        for (int n = 0; n < n_pts; n++) begin
            logic [2*W-1:0] s;
            s = (k == 3) ? fb3[rev(n, bits)] : fb6[rev(n, bits)];
            e.r   = s[2*W-1:W];
            e.i   = s[W-1:0];
            e.due = (n == 0) ? cyc + 3 : -1;
            if (k == 3) q3.push_back(e); else q6.push_back(e);
        end
        if (k == 3) fb3.delete(); else fb6.delete();
    endtask

    task automatic send(input int k, input logic en, input logic [W-1:0] r, input logic [W-1:0] i);
        @(negedge clock);
        if (k == 3) begin en3 = en; r3 = r; i3 = i; end
        else        begin en6 = en; r6 = r; i6 = i; end
        if (en) begin
            if (k == 3) begin
                fb3.push_back({r, i});
                if (fb3.size() == 8) push_frame(3);
            end else begin
                fb6.push_back({r, i});
                if (fb6.size() == 64) push_frame(6);
            end
        end
    endtask

    task automatic idle(input int k, input int n);
        for (int c = 0; c < n; c++) send(k, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_odata_en_n3", oen3, 0);
        chk("reset_odata_en_n6", oen6, 0);
        q3.delete(); q6.delete(); fb3.delete(); fb6.delete();
        en3 = 1'b0; en6 = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q3.size() != 0 || q6.size() != 0) && t < 300) begin
            @(negedge clock);
            t++;
        end
        chk("drain_pending", q3.size() + q6.size(), 0);
        idle(3, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        idle(3, 2);

        // 1: single frame, ramp data
        for (int n = 0; n < 8; n++) send(3, 1'b1, W'(n), W'($urandom));
        idle(3, 1);
        drain();

        // 2: two back-to-back frames
        for (int n = 0; n < 16; n++) send(3, 1'b1, W'(n), W'($urandom));
        idle(3, 1);
        drain();

        // 3: gapped input
        for (int n = 0; n < 8; n++) begin
            send(3, 1'b1, W'(n), W'($urandom));
            send(3, 1'b0, W'($urandom), W'($urandom));
        end
        drain();

        // 4: reset discards a partial frame
        for (int n = 0; n < 5; n++) send(3, 1'b1, W'($urandom), W'($urandom));
        do_reset();
        idle(3, 4);
        for (int n = 0; n < 8; n++) send(3, 1'b1, W'($urandom), W'(100 + n));
        idle(3, 1);
        drain();

        // 5: reset in the middle of an output frame
        for (int n = 0; n < 8; n++) send(3, 1'b1, W'($urandom), W'($urandom));
        idle(3, 4);
        do_reset();
        idle(3, 12);
        for (int n = 0; n < 8; n++) send(3, 1'b1, W'($urandom), W'($urandom));
        idle(3, 1);
        drain();

        // 6: N=64, 20 random back-to-back frames
        for (int f = 0; f < 20; f++)
            for (int n = 0; n < 64; n++) send(6, 1'b1, W'($urandom), W'($urandom));
        idle(6, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
